// File: rtl/ex_pkg.sv
// Shared types for the ID/EX stage: ALU operation codes, forward selects,
// the ID/EX pipeline register layout and the source-match helper.
package ex_pkg;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_MUL = 5'b00010;
  localparam logic [4:0] ALU_AND = 5'b00011;
  localparam logic [4:0] ALU_OR  = 5'b00100;
  localparam logic [4:0] ALU_NOR = 5'b00101;
  localparam logic [4:0] ALU_XOR = 5'b00110;
  localparam logic [4:0] ALU_SLL = 5'b00111;
  localparam logic [4:0] ALU_SRL = 5'b01000;
  localparam logic [4:0] ALU_SLT = 5'b01001;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic        valid;
    logic [4:0]  alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        alusrc;
    logic [4:0]  writereg;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
  } idex_t;

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic en, input logic [4:0] src,
                                     input logic [4:0] dst);
    return en && (dst != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard and forwarding control for the ID/EX stage.
// Forwarding is enabled by defining ID_EX_FORWARDING_EN.
module hazard_detect
  import ex_pkg::*;
(
  input  logic       reset,
  input  logic       flush,
  input  logic       id_valid,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic       ex_regwrite,
  input  logic [4:0] ex_writereg,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       exmem_regwrite,
  input  logic [4:0] exmem_writereg,
  input  logic       memwb_regwrite,
  input  logic [4:0] memwb_writereg,
  output logic       stall,
  output fwd_sel_e   fwd_a,
  output fwd_sel_e   fwd_b
);

  logic load_use_s;
  logic raw_s;

  assign load_use_s = ex_valid && ex_memread &&
                      (reg_match(id_uses_rs, id_rs, ex_writereg) ||
                       reg_match(id_uses_rt, id_rt, ex_writereg));

`ifdef ID_EX_FORWARDING_EN
  assign raw_s = 1'b0;

  // Pick the youngest producer of each EX source; EX/MEM beats MEM/WB.
  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (reg_match(exmem_regwrite, ex_rs, exmem_writereg)) begin
      fwd_a = FWD_EXMEM;
    end else if (reg_match(memwb_regwrite, ex_rs, memwb_writereg)) begin
      fwd_a = FWD_MEMWB;
    end else begin
      fwd_a = FWD_REG;
    end
    if (reg_match(exmem_regwrite, ex_rt, exmem_writereg)) begin
      fwd_b = FWD_EXMEM;
    end else if (reg_match(memwb_regwrite, ex_rt, memwb_writereg)) begin
      fwd_b = FWD_MEMWB;
    end else begin
      fwd_b = FWD_REG;
    end
  end
`else
  logic unused_fwd_s;

  // Without bypass paths every in-flight producer in EX or EX/MEM must drain.
  assign raw_s = (ex_valid && ex_regwrite &&
                  (reg_match(id_uses_rs, id_rs, ex_writereg) ||
                   reg_match(id_uses_rt, id_rt, ex_writereg))) ||
                 (reg_match(id_uses_rs, id_rs, exmem_writereg) && exmem_regwrite) ||
                 (reg_match(id_uses_rt, id_rt, exmem_writereg) && exmem_regwrite);
  assign fwd_a = FWD_REG;
  assign fwd_b = FWD_REG;
  assign unused_fwd_s = ^{memwb_regwrite, memwb_writereg, ex_rs, ex_rt};
`endif

  assign stall = (load_use_s || raw_s) && id_valid && !flush && !reset;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion and ALU operand muxes.
// Optional operand forwarding is selected with ID_EX_FORWARDING_EN.
module id_ex_stage
  import ex_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Flush,
  input  logic        ID_Valid,
  input  logic [4:0]  ID_ALUControl,
  input  logic [31:0] ID_ReadData1,
  input  logic [31:0] ID_ReadData2,
  input  logic [31:0] ID_Imm,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic [4:0]  ID_Rd,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        ID_ALUSrc,
  input  logic        ID_RegDst,
  input  logic        ID_RegWrite,
  input  logic        ID_MemRead,
  input  logic        ID_MemWrite,
  input  logic        ID_MemToReg,
  input  logic        EXMEM_RegWrite,
  input  logic [4:0]  EXMEM_WriteReg,
  input  logic [31:0] EXMEM_ALUResult,
  input  logic        MEMWB_RegWrite,
  input  logic [4:0]  MEMWB_WriteReg,
  input  logic [31:0] MEMWB_WriteData,
  output logic        Stall,
  output logic        EX_Valid,
  output logic [4:0]  EX_ALUControl,
  output logic [31:0] EX_A,
  output logic [31:0] EX_B,
  output logic [31:0] EX_StoreData,
  output logic [4:0]  EX_WriteReg,
  output logic        EX_RegWrite,
  output logic        EX_MemRead,
  output logic        EX_MemWrite,
  output logic        EX_MemToReg
);

  idex_t    ex_r;
  idex_t    id_s;
  fwd_sel_e fwd_a_s;
  fwd_sel_e fwd_b_s;
  logic [31:0] a_val_s;
  logic [31:0] b_val_s;

  hazard_detect u_hazard (
    .reset          (Reset),
    .flush          (Flush),
    .id_valid       (ID_Valid),
    .id_uses_rs     (ID_UsesRs),
    .id_uses_rt     (ID_UsesRt),
    .id_rs          (ID_Rs),
    .id_rt          (ID_Rt),
    .ex_valid       (ex_r.valid),
    .ex_memread     (ex_r.memread),
    .ex_regwrite    (ex_r.regwrite),
    .ex_writereg    (ex_r.writereg),
    .ex_rs          (ex_r.rs),
    .ex_rt          (ex_r.rt),
    .exmem_regwrite (EXMEM_RegWrite),
    .exmem_writereg (EXMEM_WriteReg),
    .memwb_regwrite (MEMWB_RegWrite),
    .memwb_writereg (MEMWB_WriteReg),
    .stall          (Stall),
    .fwd_a          (fwd_a_s),
    .fwd_b          (fwd_b_s)
  );

  // Pack the decoded ID fields into the pipeline-register layout.
  always_comb begin
    id_s          = '0;
    id_s.valid    = 1'b1;
    id_s.alu_ctrl = ID_ALUControl;
    id_s.rd1      = ID_ReadData1;
    id_s.rd2      = ID_ReadData2;
    id_s.imm      = ID_Imm;
    id_s.rs       = ID_Rs;
    id_s.rt       = ID_Rt;
    id_s.alusrc   = ID_ALUSrc;
    id_s.writereg = ID_RegDst ? ID_Rd : ID_Rt;
    id_s.regwrite = ID_RegWrite;
    id_s.memread  = ID_MemRead;
    id_s.memwrite = ID_MemWrite;
    id_s.memtoreg = ID_MemToReg;
  end

  // ID/EX register: reset, bubble, or capture; a bubble is all-zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_r <= '0;
    end else if (Flush || Stall || !ID_Valid) begin
      ex_r <= '0;
    end else begin
      ex_r <= id_s;
    end
  end

  // Operand A source mux.
  always_comb begin
    case (fwd_a_s)
      FWD_EXMEM: a_val_s = EXMEM_ALUResult;
      FWD_MEMWB: a_val_s = MEMWB_WriteData;
      default:   a_val_s = ex_r.rd1;
    endcase
  end

  // Operand rt source mux, shared by EX_B and the store data path.
  always_comb begin
    case (fwd_b_s)
      FWD_EXMEM: b_val_s = EXMEM_ALUResult;
      FWD_MEMWB: b_val_s = MEMWB_WriteData;
      default:   b_val_s = ex_r.rd2;
    endcase
  end

  assign EX_A          = a_val_s;
  assign EX_B          = ex_r.alusrc ? ex_r.imm : b_val_s;
  assign EX_StoreData  = b_val_s;
  assign EX_Valid      = ex_r.valid;
  assign EX_ALUControl = ex_r.alu_ctrl;
  assign EX_WriteReg   = ex_r.writereg;
  assign EX_RegWrite   = ex_r.regwrite;
  assign EX_MemRead    = ex_r.memread;
  assign EX_MemWrite   = ex_r.memwrite;
  assign EX_MemToReg   = ex_r.memtoreg;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 32-bit MIPS-subset datapath. It registers decoded ID-stage operands and controls, then presents final ALU operands (`EX_A`, `EX_B`) and `EX_ALUControl` directly to the ALU. It also detects load-use and RAW hazards, inserts bubbles, and drives `Stall` back to the PC and IF/ID register. Operand forwarding from EX/MEM and MEM/WB is a compile-time option.

## Interface
- No parameters; widths fixed (32-bit data, 5-bit register index, 5-bit ALU control).
- **Clocking:** one clock; reset is synchronous and active-high.
- `Clk` in 1: sole clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `Flush` in 1: taken branch/jump; discard the ID instruction.
- `ID_Valid` in 1: ID holds a real instruction.
- `ID_ALUControl` in 5: ALU operation code.
- `ID_ReadData1`, `ID_ReadData2` in 32: register-file read data.
- `ID_Imm` in 32: sign/zero-extended immediate.
- `ID_Rs`, `ID_Rt`, `ID_Rd` in 5: register indices.
- `ID_UsesRs`, `ID_UsesRt` in 1: the instruction reads that source.
- `ID_ALUSrc`, `ID_RegDst`, `ID_RegWrite`, `ID_MemRead`, `ID_MemWrite`, `ID_MemToReg` in 1: decoded controls.
- `EXMEM_RegWrite` in 1, `EXMEM_WriteReg` in 5, `EXMEM_ALUResult` in 32: EX/MEM producer.
- `MEMWB_RegWrite` in 1, `MEMWB_WriteReg` in 5, `MEMWB_WriteData` in 32: MEM/WB producer.
- `Stall` out 1: hold PC and IF/ID this cycle.
- `EX_Valid` out 1: EX holds a real instruction.
- `EX_ALUControl` out 5; `EX_A`, `EX_B` out 32: ALU inputs.
- `EX_StoreData` out 32: forwarded rt value for stores.
- `EX_WriteReg` out 5: `Rd` if RegDst, else `Rt`.
- `EX_RegWrite`, `EX_MemRead`, `EX_MemWrite`, `EX_MemToReg` out 1.

## Operation
- **Per-cycle register update:** each rising edge, the ID/EX register takes exactly one of:
  - zero (Reset),
  - a bubble (Flush, Stall, or `!ID_Valid`),
  - the ID contents.
- **Bubble contents:** `EX_Valid`=0, all control outputs 0, `EX_WriteReg`=0; data fields may hold any value.
- **Load-use hazard:** asserted when all hold:
  - EX is valid and `EX_MemRead`=1,
  - `EX_WriteReg`≠0,
  - (`ID_UsesRs` and `ID_Rs`=`EX_WriteReg`) or (`ID_UsesRt` and `ID_Rt`=`EX_WriteReg`).
- **Stall:** `Stall` = hazard & `ID_Valid` & !`Flush` & !`Reset`.
  - The stalled instruction re-presents next cycle with the same inputs.
- **Flush priority:** Flush overrides Stall; a bubble enters and `Stall`=0.
- **Operand selection:**
  - Forwarded rs value → `EX_A`.
  - Forwarded rt value → `EX_StoreData`.
  - `EX_B` = `ALUSrc` ? registered Imm : forwarded rt value.
- **Register 0:** never matches any hazard or forward.

## Timing
- **Latency:** 1 cycle ID→EX.
- **Combinational outputs:**
  - `Stall` depends on current ID inputs and registered EX state.
  - `EX_A`, `EX_B`, `EX_StoreData` depend on registered state plus current EXMEM/MEMWB inputs.
- **Reset values:** all registered outputs 0, so `EX_A`/`EX_B` = 0 (and selects ALU ADD); `Stall`=0.
- **Reset mid-stall:** the stall is abandoned; next cycle is a clean bubble.
- **Repeated stall:** `Stall` lasts exactly 1 cycle per load-use pair. The load moves on, so the re-presented instruction no longer matches.

## Configuration
- **`ID_EX_FORWARDING_EN` defined:** forwarding active.
  - Source matches `EXMEM_WriteReg` (with `EXMEM_RegWrite`) → use `EXMEM_ALUResult`.
  - Else matches `MEMWB_WriteReg` (with `MEMWB_RegWrite`) → use `MEMWB_WriteData`.
  - Else use the registered read data. EX/MEM has priority.
- **Undefined:** no forwarding; operands come straight from registered read data.
  - Hazard widens: stall when a used ID source matches a valid EX `EX_WriteReg` with `EX_RegWrite`, or `EXMEM_WriteReg` with `EXMEM_RegWrite` (nonzero).
  - MEM/WB is not checked; the register file writes before it reads.

## Structure
- **Package `ex_pkg`:**
  - ALU control codes: ADD 00000, SUB 00001, MUL 00010, AND 00011, OR 00100, NOR 00101, XOR 00110, SLL 00111, SRL 01000, SLT 01001.
  - Forward-select enum {FWD_REG, FWD_EXMEM, FWD_MEMWB}.
- **Sub-module `hazard_detect`:** combinational; computes `Stall` and both forward selects.
- **Top:** the ID/EX register, bubble insertion, and the operand muxes.

## Test plan
- **Reset:** hold Reset 2 cycles with ID_Valid=1 → `EX_Valid`=0, `EX_A`=`EX_B`=0, `Stall`=0.
- **Pass-through:** ADD, ReadData1=10, ReadData2=15, ALUSrc=0, Rd=3, RegDst=1 → next cycle `EX_A`=10, `EX_B`=15, `EX_WriteReg`=3, `EX_RegWrite`=1.
- **Load-use:** `lw $8` then `sub` using Rs=8 → `Stall`=1 for one cycle, bubble enters EX, then sub proceeds.
  - With MEMWB forwarding `$8`=20 and Rt=5, `EX_A`=20 → ALU yields 15.
- **Forward priority:** EXMEM writes `$4`=7 and MEMWB writes `$4`=9, ID/EX Rs=4 → `EX_A`=7.
  - With writes to `$0` instead → registered value used.
- **Flush over stall:** Flush=1 during a load-use condition → `Stall`=0, next `EX_Valid`=0, `EX_MemWrite`=0.
- **Forwarding disabled:** build without `ID_EX_FORWARDING_EN`; `add $2` followed by a use of `$2` → `Stall` for 2 cycles, then `EX_A` equals the register-file value.
